// File: rtl/sram_responder.sv
// sram_responder: 16-bit Avalon-MM slave driving an external asynchronous SRAM.
// One access at a time. Back-pressure comes from s_waitrequest. Read data is
// returned with a single-cycle s_readdatavalid pulse. All SRAM strobes come
// straight from flops, so they do not glitch at the pins.
module sram_responder #(
  parameter int SRAM_AW    = 18,
  parameter int READ_WAIT  = 1,
  parameter int WRITE_WAIT = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [25:0]        s_address,
  input  logic               s_read,
  input  logic               s_write,
  input  logic [1:0]         s_byteenable,
  input  logic [15:0]        s_writedata,
  output logic [15:0]        s_readdata,
  output logic               s_readdatavalid,
  output logic               s_waitrequest,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n,
  output logic               sram_ub_n,
  output logic               sram_lb_n
);

  localparam int MAX_WAIT = (READ_WAIT > WRITE_WAIT) ? READ_WAIT : WRITE_WAIT;
  localparam int CW       = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  // Byte-address bit 0 and the address bits above the SRAM range are not used.
  // They are folded into a deliberately unused net.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_address[25:SRAM_AW+1], s_address[0]};

  // The busy flag is decoded from state alone. A registered copy would add a
  // cycle and break the acceptance timing of the back-to-back halfword pair.
  assign s_waitrequest = (state != IDLE);

  // This block holds the access sequencer and every registered SRAM strobe.
  // NOTE: reset is asynchronous. Asserting it in any state releases the SRAM
  // bus in the same cycle, and it discards a read that is still in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      cnt             <= '0;
      sram_addr       <= '0;
      sram_dq_out     <= '0;
      sram_dq_oe      <= 1'b0;
      sram_ce_n       <= 1'b1;
      sram_oe_n       <= 1'b1;
      sram_we_n       <= 1'b1;
      sram_ub_n       <= 1'b1;
      sram_lb_n       <= 1'b1;
      s_readdata      <= '0;
      s_readdatavalid <= 1'b0;
    end else begin
      // NOTE: use non-blocking assignments only. Every branch then sees the
      // values from before the edge, and the default pulse clear below is
      // overridden cleanly when RD completes.
      s_readdatavalid <= 1'b0;
      case (state)
        IDLE: begin
          if (s_write) begin
            // If a read is requested at the same time, the write takes priority
            // and the read is dropped.
            sram_addr   <= s_address[SRAM_AW:1];
            sram_dq_out <= s_writedata;
            sram_ub_n   <= ~s_byteenable[1];
            sram_lb_n   <= ~s_byteenable[0];
            sram_ce_n   <= 1'b0;
            sram_dq_oe  <= 1'b1;
            sram_we_n   <= 1'b1;
            state       <= WR_SETUP;
          end else if (s_read) begin
            // Reads always fetch the full word and ignore byteenable.
            sram_addr <= s_address[SRAM_AW:1];
            sram_ce_n <= 1'b0;
            sram_oe_n <= 1'b0;
            sram_ub_n <= 1'b0;
            sram_lb_n <= 1'b0;
            cnt       <= CW'(READ_WAIT);
            state     <= RD;
          end
        end

        RD: begin
          if (cnt == '0) begin
            s_readdata      <= sram_dq_in;
            s_readdatavalid <= 1'b1;
            sram_ce_n       <= 1'b1;
            sram_oe_n       <= 1'b1;
            sram_ub_n       <= 1'b1;
            sram_lb_n       <= 1'b1;
            state           <= IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        WR_SETUP: begin
          sram_we_n <= 1'b0;
          cnt       <= CW'(WRITE_WAIT);
          state     <= WR_PULSE;
        end

        WR_PULSE: begin
          if (cnt == '0) begin
            sram_we_n <= 1'b1;
            state     <= WR_HOLD;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        WR_HOLD: begin
          // DQ drive drops here. A following read's OE therefore falls at least
          // one full cycle later, after the IDLE accept cycle.
          sram_ce_n  <= 1'b1;
          sram_dq_oe <= 1'b0;
          sram_ub_n  <= 1'b1;
          sram_lb_n  <= 1'b1;
          state      <= IDLE;
        end

        default: begin
          sram_ce_n  <= 1'b1;
          sram_oe_n  <= 1'b1;
          sram_we_n  <= 1'b1;
          sram_ub_n  <= 1'b1;
          sram_lb_n  <= 1'b1;
          sram_dq_oe <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule
